// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } fetch_state_e;

    localparam logic [31:0] INS_NOP = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC+4 while decode is stalled.
module fetch_buf
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [31:0]       ins_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic              valid_o,
    output logic [31:0]       ins_o,
    output logic [ADDR_W-1:0] pc4_o
);

    logic              valid_q;
    logic [31:0]       ins_q;
    logic [ADDR_W-1:0] pc4_q;

    // Clear wins over load so a redirect always empties the buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            ins_q   <= INS_NOP;
            pc4_q   <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ins_q   <= ins_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign ins_o   = ins_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage controller: PC sequencing, IMEM handshake, stall buffering and branch redirect.
// Build macro DELAY_SLOT_EN keeps the instruction completing on a redirect as a delay slot.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              STALL,
    input  logic              BR_TAKEN,
    input  logic [ADDR_W-1:0] BR_TARGET,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_RDY,
    input  logic [31:0]       IMEM_DATA,
    output logic [ADDR_W-1:0] PC,
    output logic [31:0]       IFID_INS,
    output logic [ADDR_W-1:0] IFID_PC4,
    output logic              IFID_VALID
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              valid_q, valid_d;

    logic              buf_load, buf_clr, buf_valid;
    logic [31:0]       buf_ins;
    logic [ADDR_W-1:0] buf_pc4;
    logic [ADDR_W-1:0] pc_plus4;
    logic              complete;

    // Target is word-aligned, so its low two bits never reach the PC.
    logic unused_tgt_bits;
    assign unused_tgt_bits = ^BR_TARGET[1:0];

    assign pc_plus4 = pc_q + ADDR_W'(PC_STEP);
    assign complete = (state_q == S_REQ) && IMEM_RDY;

    fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .load_i  (buf_load),
        .clr_i   (buf_clr),
        .ins_i   (IMEM_DATA),
        .pc4_i   (pc_plus4),
        .valid_o (buf_valid),
        .ins_o   (buf_ins),
        .pc4_o   (buf_pc4)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ins_q   <= INS_NOP;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ins_d    = ins_q;
        pc4_d    = pc4_q;
        valid_d  = valid_q;
        buf_load = 1'b0;
        buf_clr  = 1'b0;

        if (BR_TAKEN) begin
            pc_d    = {BR_TARGET[ADDR_W-1:2], 2'b00};
            state_d = S_REQ;
            buf_clr = 1'b1;
`ifdef DELAY_SLOT_EN
            if (complete) begin
                ins_d   = IMEM_DATA;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
            end else if ((state_q == S_HOLD) && buf_valid) begin
                ins_d   = buf_ins;
                pc4_d   = buf_pc4;
                valid_d = 1'b1;
            end else if (!STALL) begin
                valid_d = 1'b0;
            end
`else
            valid_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ: begin
                    if (complete) begin
                        if (STALL) begin
                            buf_load = 1'b1;
                            state_d  = S_HOLD;
                        end else begin
                            ins_d   = IMEM_DATA;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end
                    end else if (!STALL) begin
                        valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!STALL) begin
                        ins_d   = buf_ins;
                        pc4_d   = buf_pc4;
                        valid_d = buf_valid;
                        pc_d    = pc_plus4;
                        buf_clr = 1'b1;
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign IMEM_REQ   = (state_q == S_REQ);
    assign IMEM_ADDR  = pc_q;
    assign PC         = pc_q;
    assign IFID_INS   = ins_q;
    assign IFID_PC4   = pc4_q;
    assign IFID_VALID = valid_q;

endmodule
